glyph_row_serializer: RTL

- Reads a 5x5 character glyph one row at a time from a combinational glyph-row ROM (row index in, 5-bit row bitmap out).
- Serializes each row into a pixel stream for the VGA calculator display, leftmost column (bitmap MSB) first.
- Uses a valid/ready handshake towards the downstream pixel writer.
- Sits between the per-character glyph ROMs and the frame/pixel write logic.

---
 rtl/glyph_row_serializer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/glyph_row_serializer.sv
// glyph_row_serializer
// Walks a ROWS x COLS glyph one row at a time through a combinational
// glyph-row ROM and serializes each row into a valid/ready pixel stream.
// The leftmost column (the bitmap MSB) is emitted first, and each column is
// repeated SCALE times.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             one-cycle render request, honoured only when idle
//   row_sel/row_code  row index to the ROM / bitmap returned for that row
//   pix_valid/ready   pixel beat handshake towards the pixel writer
//   pix_on            pixel value (0 whenever pix_valid is low)
//   pix_row/pix_col   glyph coordinates of the current beat
//   busy, done        render in progress / one-cycle completion pulse
module glyph_row_serializer #(
    parameter int unsigned ROWS  = 5,
    parameter int unsigned COLS  = 5,
    parameter int unsigned SCALE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [2:0]      row_sel,
    input  logic [COLS-1:0] row_code,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            pix_on,
    output logic [2:0]      pix_row,
    output logic [2:0]      pix_col,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] row_next;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] col_next;
    logic [CNT_W-1:0] rep;
    logic [CNT_W-1:0] rep_next;
    logic [COLS-1:0]  shreg;
    logic [COLS-1:0]  shreg_next;

    logic pix_valid_next;
    logic pix_on_next;
    logic busy_next;
    logic done_next;

    logic accept;
    logic last_rep;
    logic last_col;
    logic last_row;

    assign accept   = (state == S_SHIFT) && pix_ready;
    assign last_rep = (rep == CNT_W'(SCALE - 1));
    assign last_col = (col == CNT_W'(COLS - 1));
    assign last_row = (row == CNT_W'(ROWS - 1));

    // The ROM address and beat coordinates are the counters themselves.
    assign row_sel = row;
    assign pix_row = row;
    assign pix_col = col;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            col       <= '0;
            rep       <= '0;
            shreg     <= '0;
            pix_valid <= 1'b0;
            pix_on    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            row       <= row_next;
            col       <= col_next;
            rep       <= rep_next;
            shreg     <= shreg_next;
            pix_valid <= pix_valid_next;
            pix_on    <= pix_on_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        rep_next   = rep;
        shreg_next = shreg;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    row_next   = '0;
                end
            end
            S_LOAD: begin
                shreg_next = row_code;
                col_next   = '0;
                rep_next   = '0;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (accept) begin
                    if (!last_rep) begin
                        rep_next = rep + CNT_W'(1);
                    end else begin
                        rep_next   = '0;
                        shreg_next = {shreg[COLS-2:0], 1'b0};
                        col_next   = col + CNT_W'(1);
                        // End of row: park the column counter at 0 rather than wrapping past COLS-1.
                        if (last_col) begin
                            col_next = '0;
                            if (last_row) begin
                                state_next = S_DONE;
                            end else begin
                                row_next   = row + CNT_W'(1);
                                state_next = S_LOAD;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                row_next   = '0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the upcoming state, so they line up with it
    always_comb begin
        pix_valid_next = 1'b0;
        pix_on_next    = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        pix_valid_next = (state_next == S_SHIFT);
        pix_on_next    = pix_valid_next && shreg_next[COLS-1];
        busy_next      = (state_next != S_IDLE);
        done_next      = (state_next == S_DONE);
    end

endmodule
